bus_rr_scheduler: RTL and testbench
===================================

Name: bus_rr_scheduler

Overview:
- Round-robin scheduler that shares one broadcast bus among drvrs driver FIFOs.
- Grants one pending source at a time, pops one packet from it, and decodes the destination ID in the packet header.
- Pushes the packet to one destination FIFO, or to all other FIFOs on broadcast, and holds the push while any target FIFO is full.
- Sits between the per-driver FIFO interfaces (pndng/pop/D_pop in, push/D_push out) and replaces free-running arbitration with fair, backpressure-aware sequencing.

Parameters:
- pckg_sz, 16, packet width in bits; header ID = D[pckg_sz-1 -: 8].
- drvrs, 8, number of drivers/FIFOs (2..255).
- bcast_id, 8'hFF, header ID that means broadcast.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pndng  in  drvrs  source FIFO i non-empty; FIFOs are first-word-fall-through, so D_pop is valid while pndng is high.
- D_pop  in  drvrs*pckg_sz  head word of source FIFO i, slice [i*pckg_sz +: pckg_sz].
- pop  out  drvrs  one-cycle pop strobe to source FIFO i.
- full  in  drvrs  destination FIFO i cannot accept a push.
- push  out  drvrs  push strobe per destination FIFO.
- D_push  out  pckg_sz  shared bus data, valid while any push bit is high.
- grant_id  out  $clog2(drvrs)  currently granted source.
- busy  out  1  high in any state other than IDLE.
- err_drop  out  1  one-cycle pulse when a packet is discarded for an invalid ID.

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0, pkt=0, mask=0. pop=0, push=0, D_push=0, grant_id=0, busy=0, err_drop=0. Reset mid-transfer aborts immediately; the in-flight packet is lost; push drops to 0 in the same instant.
- FSM states: IDLE, POP, ROUTE, DELIVER.
- IDLE:
  - If |pndng, latch g = first i with pndng[i], searching from rr_ptr upward modulo drvrs; grant_id<=g; go to POP.
  - Otherwise stay in IDLE.
- POP:
  - pop[g]=1 for exactly this cycle.
  - pkt<=D_pop[g] at this edge; go to ROUTE.
  - If pndng[g] has dropped: no pop, go to IDLE, rr_ptr unchanged.
- ROUTE: compute id=pkt[pckg_sz-1 -: 8].
  - id==bcast_id: mask = all ones except bit g.
  - id<drvrs and id!=g: mask = onehot(id).
  - Otherwise (id>=drvrs and not broadcast, or id==g): err_drop=1 for one cycle, rr_ptr<=(g+1)%drvrs, go to IDLE.
  - Valid ID: go to DELIVER.
- DELIVER:
  - If (mask & full)==0: push=mask and D_push=pkt for this one cycle, rr_ptr<=(g+1)%drvrs, go to IDLE.
  - Else stay: push=0, D_push holds pkt.
  - Broadcast is atomic: all targets are pushed in the same cycle or not at all.
  - No timeout.
- Latency: pop occurs 1 cycle after pndng is sampled in IDLE; push occurs 2 cycles after the pop cycle when full is low. Minimum 4 cycles per packet; back-to-back grants are allowed with no extra idle cycle beyond IDLE.
- Fairness: a source that keeps pndng high waits at most drvrs-1 grants.
- rr_ptr wraps from drvrs-1 to 0.
- full and pndng are sampled only in the states above; changes elsewhere are ignored.
- At most one pop bit is ever high. pop and push are never high in the same cycle.

Decomposition:
- Package bus_sched_pkg holds:
  - state_t enum {IDLE, POP, ROUTE, DELIVER};
  - ID_W=8;
  - default BCAST_ID;
  - function dest_mask(id, src, drvrs).
- One sub-module, rr_picker: combinational; inputs req[drvrs] and ptr; outputs gnt_idx and any_req. Reusable by other arbiters.

Test Plan:
- Single unicast, drvrs=8, pckg_sz=16, all full=0: pndng[2]=1, D_pop[2]=16'h05AB -> pop=8'b0000_0100 for one cycle; push=8'b0010_0000 and D_push=16'h05AB two cycles later; busy falls the next cycle.
- Broadcast from source 3, D_pop[3]=16'hFF12 -> push=8'b1111_0111, D_push=16'hFF12, exactly one cycle.
- Contention: pndng=8'b1000_0011 held with rr_ptr=0, each source sends one packet then empties -> grant order 0, 1, 7; rr_ptr ends at 0 (wrap).
- Backpressure: unicast to 5 with full[5]=1 for 10 cycles -> push stays 0 and busy=1 throughout; push[5] pulses in the first cycle after full[5] falls. Broadcast with only full[6]=1 -> no push bit asserted until full[6]=0.
- Invalid ID: D_pop[1]=16'h09CD, then 16'h01CD from source 1 -> each gives pop[1], one err_drop pulse, no push; the next grant goes to the next pending source after 1.
- Reset mid-DELIVER while stalled on full -> push, busy, and grant_id are 0 immediately; after release, the packet is not re-sent, and a new pndng is granted starting from rr_ptr=0.

Source files
------------

// File: rtl/bus_sched_pkg.sv
// Shared types and helpers for the round-robin broadcast-bus scheduler.
package bus_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        POP     = 2'd1,
        ROUTE   = 2'd2,
        DELIVER = 2'd3
    } state_t;

    localparam int ID_W = 8;
    localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;
    localparam int MAX_DRVRS = 256;

    // Destination mask for a header ID; an all-zero result marks the ID as undeliverable.
    function automatic logic [MAX_DRVRS-1:0] dest_mask(
        input logic [ID_W-1:0] id,
        input logic [ID_W-1:0] src,
        input int              drvrs,
        input logic [ID_W-1:0] bcast
    );
        logic [MAX_DRVRS-1:0] m;
        m = '0;
        if (id == bcast) begin
            for (int i = 0; i < MAX_DRVRS; i++) begin
                m[i] = (i < drvrs) && (i != int'(src));
            end
        end else if ((int'(id) < drvrs) && (id != src)) begin
            m[id] = 1'b1;
        end else begin
            m = '0;
        end
        return m;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping modulo N.
module rr_picker #(
    parameter int N = 8,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] gnt_idx,
    output logic         any_req
);

    logic [W-1:0] idx_s;

    // Scan offsets from farthest to nearest so the closest request to ptr wins.
    always_comb begin
        gnt_idx = '0;
        idx_s   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx_s   = W'((int'(ptr) + k) % N);
            gnt_idx = req[idx_s] ? idx_s : gnt_idx;
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/bus_rr_scheduler.sv
// Round-robin scheduler sharing one broadcast bus among drvrs FWFT source FIFOs,
// with atomic, backpressure-aware delivery to one or all other destination FIFOs.
import bus_sched_pkg::*;

module bus_rr_scheduler #(
    parameter int              pckg_sz  = 16,
    parameter int              drvrs    = 8,
    parameter logic [ID_W-1:0] bcast_id = BCAST_ID,
    parameter int              GW       = (drvrs > 1) ? $clog2(drvrs) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [drvrs-1:0]           pndng,
    input  logic [drvrs*pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]           pop,
    input  logic [drvrs-1:0]           full,
    output logic [drvrs-1:0]           push,
    output logic [pckg_sz-1:0]         D_push,
    output logic [GW-1:0]              grant_id,
    output logic                       busy,
    output logic                       err_drop
);

    state_t               state_r;
    state_t               state_nxt_s;
    logic [GW-1:0]        rr_ptr_r;
    logic [GW-1:0]        grant_r;
    logic [GW-1:0]        pick_idx_s;
    logic [GW-1:0]        next_ptr_s;
    logic                 pick_any_s;
    logic [pckg_sz-1:0]   pkt_r;
    logic [pckg_sz-1:0]   head_s;
    logic [drvrs-1:0]     mask_r;
    logic [MAX_DRVRS-1:0] dm_s;
    logic                 id_ok_s;
    logic                 src_live_s;
    logic                 push_ok_s;

    rr_picker #(
        .N (drvrs),
        .W (GW)
    ) u_picker (
        .req     (pndng),
        .ptr     (rr_ptr_r),
        .gnt_idx (pick_idx_s),
        .any_req (pick_any_s)
    );

    assign dm_s       = dest_mask(pkt_r[pckg_sz-1 -: ID_W], ID_W'(grant_r), drvrs, bcast_id);
    assign id_ok_s    = |dm_s;
    assign src_live_s = pndng[grant_r];
    // Broadcast stays atomic: any full target blocks the whole push.
    assign push_ok_s  = ~|(mask_r & full);
    assign next_ptr_s = (int'(grant_r) == drvrs - 1) ? '0 : grant_r + GW'(1);
    assign grant_id   = grant_r;

    // Head word of the granted source FIFO.
    always_comb begin
        head_s = '0;
        for (int i = 0; i < drvrs; i++) begin
            if (grant_r == GW'(i)) begin
                head_s = D_pop[i*pckg_sz +: pckg_sz];
            end else begin
                head_s = head_s;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = pick_any_s ? POP : IDLE;
            POP:     state_nxt_s = src_live_s ? ROUTE : IDLE;
            ROUTE:   state_nxt_s = id_ok_s ? DELIVER : IDLE;
            DELIVER: state_nxt_s = push_ok_s ? IDLE : DELIVER;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Grant, packet, mask and round-robin pointer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_r <= '0;
            grant_r  <= '0;
            pkt_r    <= '0;
            mask_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_any_s) begin
                        grant_r <= pick_idx_s;
                    end
                end
                POP: begin
                    if (src_live_s) begin
                        pkt_r <= head_s;
                    end
                end
                ROUTE: begin
                    mask_r <= dm_s[drvrs-1:0];
                    if (!id_ok_s) begin
                        rr_ptr_r <= next_ptr_s;
                    end
                end
                DELIVER: begin
                    if (push_ok_s) begin
                        rr_ptr_r <= next_ptr_s;
                    end
                end
                default: begin
                    rr_ptr_r <= rr_ptr_r;
                end
            endcase
        end
    end

    // Output decode; pop and push depend on live pndng/full so they react in the same cycle.
    always_comb begin
        pop      = '0;
        push     = '0;
        D_push   = '0;
        err_drop = 1'b0;
        busy     = 1'b1;
        case (state_r)
            IDLE: begin
                busy = 1'b0;
            end
            POP: begin
                if (src_live_s) begin
                    pop[grant_r] = 1'b1;
                end else begin
                    pop = '0;
                end
            end
            ROUTE: begin
                err_drop = ~id_ok_s;
            end
            DELIVER: begin
                D_push = pkt_r;
                if (push_ok_s) begin
                    push = mask_r;
                end else begin
                    push = '0;
                end
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Scoreboard bench for bus_rr_scheduler: source FIFO model, expected pop/output queues, directed timing checks.
module tb_bus_rr_scheduler;

    localparam int N = 8;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   pndng = '0;
    logic [N*W-1:0] D_pop = '0;
    logic [N-1:0]   pop;
    logic [N-1:0]   full = '0;
    logic [N-1:0]   push;
    logic [W-1:0]   D_push;
    logic [2:0]     grant_id;
    logic           busy;
    logic           err_drop;

    always #5 clk = ~clk;

    bus_rr_scheduler #(.pckg_sz(W), .drvrs(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (D_pop),
        .pop      (pop),
        .full     (full),
        .push     (push),
        .D_push   (D_push),
        .grant_id (grant_id),
        .busy     (busy),
        .err_drop (err_drop)
    );

    logic [15:0] src_q [N][$];
    logic [7:0]  pop_q [$];
    logic [24:0] out_q [$];
    int total = 0;
    int bad = 0;
    int pend_idx = -1;
    int push_seen = 0;
    int seen_snap;

    task check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task refresh();
        for (int i = 0; i < N; i++) begin
            pndng[i] = (src_q[i].size() != 0);
            D_pop[i*W +: W] = (src_q[i].size() != 0) ? src_q[i][0] : 16'h0000;
        end
    endtask

    task send(input int src, input logic [15:0] word);
        logic [7:0] id;
        logic [7:0] m;
        logic       err;
        id  = word[15:8];
        m   = 8'h00;
        err = 1'b0;
        if (id == 8'hFF) m = ~(8'h01 << src);
        else if ((id < 8'd8) && (int'(id) != src)) m = 8'h01 << id;
        else err = 1'b1;
        src_q[src].push_back(word);
        pop_q.push_back(8'h01 << src);
        out_q.push_back(err ? {1'b1, 8'h00, 16'h0000} : {1'b0, m, word});
        refresh();
    endtask

    task wait_pop();
        int n;
        n = 0;
        while (pop == 8'h00 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("pop_seen", {31'd0, pop != 8'h00}, 32'd1);
    endtask

    task drain();
        int n;
        n = 0;
        while ((out_q.size() != 0 || pop_q.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", {31'd0, n < 200}, 32'd1);
    endtask

    // Monitor: retire popped words from the source model, then score pops and bus outputs.
    always @(negedge clk) begin
        if (reset) begin
            if (pend_idx >= 0) begin
                void'(src_q[pend_idx].pop_front());
                pend_idx = -1;
                refresh();
            end
            if (pop != 8'h00) begin
                if (pop_q.size() == 0) check_eq("pop_unexp", {24'd0, pop}, 32'd0);
                else check_eq("pop_order", {24'd0, pop}, {24'd0, pop_q.pop_front()});
                for (int i = 0; i < N; i++) if (pop[i]) pend_idx = i;
            end
            if (push != 8'h00 || err_drop) begin
                push_seen++;
                if (out_q.size() == 0) check_eq("out_unexp", {7'd0, err_drop, push, D_push}, 32'd0);
                else check_eq("out", {7'd0, err_drop, push, D_push}, {7'd0, out_q.pop_front()});
            end
        end
    end

    initial begin
        #2 reset = 1'b0;
        #10;
        check_eq("rst_pop", {24'd0, pop}, 32'd0);
        check_eq("rst_push", {24'd0, push}, 32'd0);
        check_eq("rst_dpush", {16'd0, D_push}, 32'd0);
        check_eq("rst_gid", {29'd0, grant_id}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_err", {31'd0, err_drop}, 32'd0);
        @(posedge clk); #1 reset = 1'b1;

        // contention 0,1,7 from rr_ptr=0, then wrap check
        @(posedge clk); #1;
        send(0, 16'h0311); send(1, 16'h0422); send(7, 16'h0077);
        drain();
        @(posedge clk); #1;
        send(0, 16'h0433); send(1, 16'h0244);
        drain();

        // single unicast with latency
        @(posedge clk); #1;
        send(2, 16'h05AB);
        wait_pop();
        check_eq("t1_pop", {24'd0, pop}, 32'h04);
        @(negedge clk); @(negedge clk);
        check_eq("t1_push", {24'd0, push}, 32'h20);
        check_eq("t1_dpush", {16'd0, D_push}, 32'h05AB);
        @(negedge clk);
        check_eq("t1_push_off", {24'd0, push}, 32'd0);
        check_eq("t1_busy_off", {31'd0, busy}, 32'd0);
        drain();

        // broadcast
        @(posedge clk); #1;
        send(3, 16'hFF12);
        wait_pop();
        @(negedge clk); @(negedge clk);
        check_eq("bc_push", {24'd0, push}, 32'hF7);
        check_eq("bc_dpush", {16'd0, D_push}, 32'hFF12);
        @(negedge clk);
        check_eq("bc_once", {24'd0, push}, 32'd0);
        drain();

        // unicast backpressure
        @(posedge clk); #1;
        full = 8'h20;
        send(4, 16'h05C3);
        wait_pop();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("bp_hold", {24'd0, push}, 32'd0);
            check_eq("bp_busy", {31'd0, busy}, 32'd1);
        end
        @(posedge clk); #1 full = 8'h00;
        @(negedge clk);
        check_eq("bp_release", {24'd0, push}, 32'h20);
        drain();

        // broadcast backpressure on a single target
        @(posedge clk); #1;
        full = 8'h40;
        send(0, 16'hFF34);
        wait_pop();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq("bbp_hold", {24'd0, push}, 32'd0);
        end
        @(posedge clk); #1 full = 8'h00;
        @(negedge clk);
        check_eq("bbp_release", {24'd0, push}, 32'hFE);
        drain();

        // invalid IDs interleaved with valid traffic
        @(posedge clk); #1;
        send(1, 16'h09CD); send(5, 16'h0266); send(0, 16'h0255); send(1, 16'h01CD);
        drain();

        // reset while stalled in delivery
        @(posedge clk); #1;
        full = 8'h08;
        send(6, 16'h03EE);
        wait_pop();
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_eq("mr_push", {24'd0, push}, 32'd0);
        check_eq("mr_busy", {31'd0, busy}, 32'd0);
        check_eq("mr_gid", {29'd0, grant_id}, 32'd0);
        out_q.delete();
        full = 8'h00;
        @(posedge clk); #1 reset = 1'b1;
        seen_snap = push_seen;
        repeat (6) @(negedge clk);
        check_eq("no_resend", push_seen, seen_snap);
        @(posedge clk); #1;
        send(1, 16'h0455); send(3, 16'h0266);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
